// File: rtl/sample_tick_pkg.sv
// rtl/sample_tick_pkg.sv - shared types, rate table and period helper for the sampling tick generator
package sample_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          RATE_NUM     = 9;
    localparam int          RATE_MAX     = 8;
    localparam int          DIV_W_DEF    = 26;
    localparam int unsigned CLK_FREQ_DEF = 50_000_000;

    // Clock cycles per tick for a rate index; a rate faster than the clock degenerates to every cycle.
    function automatic int unsigned period_of(input int unsigned clk_hz, input int idx);
        int unsigned rate_hz;
        int unsigned p;
        case (idx)
            0:       rate_hz = 50_000_000;
            1:       rate_hz = 5_000_000;
            2:       rate_hz = 1_000_000;
            3:       rate_hz = 100_000;
            4:       rate_hz = 10_000;
            5:       rate_hz = 1_000;
            6:       rate_hz = 100;
            7:       rate_hz = 10;
            default: rate_hz = 1;
        endcase
        p = clk_hz / rate_hz;
        return (p == 0) ? 1 : p;
    endfunction

    localparam int unsigned PERIOD_LUT [RATE_NUM] = '{
        period_of(CLK_FREQ_DEF, 0), period_of(CLK_FREQ_DEF, 1), period_of(CLK_FREQ_DEF, 2),
        period_of(CLK_FREQ_DEF, 3), period_of(CLK_FREQ_DEF, 4), period_of(CLK_FREQ_DEF, 5),
        period_of(CLK_FREQ_DEF, 6), period_of(CLK_FREQ_DEF, 7), period_of(CLK_FREQ_DEF, 8)
    };

endpackage

// File: rtl/sample_tick_div.sv
// rtl/sample_tick_div.sv - loadable modulo-P down counter with a first-period phase offset
module sample_tick_div #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    input  logic [DIV_W-1:0] phase,
    output logic             term
);

    localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

    // One extra bit so P-1+phase (up to 2P-2) never wraps.
    logic [DIV_W:0]   cnt_q, cnt_d, cur, ph_ext, per_ext;
    logic [DIV_W-1:0] period_q, per_sel;

    always_comb begin
        per_sel = load ? period : period_q;
        per_ext = {1'b0, per_sel};
        ph_ext  = (phase >= period) ? ({1'b0, period} - ONE) : {1'b0, phase};
        cur     = load ? ({1'b0, period} + ph_ext - ONE) : cnt_q;
        term    = (load | en) && (cur == '0);
        cnt_d   = cnt_q;
        if (load | en) begin
            cnt_d = term ? (per_ext - ONE) : (cur - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                period_q <= period;
            end
        end
    end

endmodule

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - start/stop sampling strobe generator in the fundamental clock domain
// Optional first-tick phase offset port enabled by SAMPLE_TICK_PHASE_EN.
module sample_tick_gen
    import sample_tick_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_DEF,
    parameter int          CNT_W       = 16,
    parameter int          DIV_W       = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rate_sel,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
`ifdef SAMPLE_TICK_PHASE_EN
    input  logic [DIV_W-1:0] phase,
`endif
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_count,
    output logic             sel_err
);

    localparam int unsigned RATE_PERIOD [RATE_NUM] = '{
        period_of(CLK_FREQ_HZ, 0), period_of(CLK_FREQ_HZ, 1), period_of(CLK_FREQ_HZ, 2),
        period_of(CLK_FREQ_HZ, 3), period_of(CLK_FREQ_HZ, 4), period_of(CLK_FREQ_HZ, 5),
        period_of(CLK_FREQ_HZ, 6), period_of(CLK_FREQ_HZ, 7), period_of(CLK_FREQ_HZ, 8)
    };

    state_e           state_q;
    logic             tick_q, busy_q, done_q, sel_err_q;
    logic [CNT_W-1:0] tick_count_q, burst_q, cnt_base, burst_base;
    logic [CNT_W:0]   tick_num;
    logic [3:0]       rate_idx;
    logic [DIV_W-1:0] period_sel, phase_w;
    logic             accept, div_en, term, last;

`ifdef SAMPLE_TICK_PHASE_EN
    assign phase_w = phase;
`else
    assign phase_w = '0;
`endif

    always_comb begin
        rate_idx   = (rate_sel > 4'(RATE_MAX)) ? 4'(RATE_MAX) : rate_sel;
        period_sel = DIV_W'(RATE_PERIOD[RATE_MAX]);
        for (int i = 0; i < RATE_NUM; i++) begin
            if (rate_idx == 4'(i)) begin
                period_sel = DIV_W'(RATE_PERIOD[i]);
            end
        end
        accept     = (state_q == IDLE) && start && !stop;
        div_en     = (state_q == RUN) && !stop;
        // On the accepting edge the tick being issued is counted against the new burst length.
        cnt_base   = accept ? '0 : tick_count_q;
        burst_base = accept ? burst_len : burst_q;
        tick_num   = {1'b0, cnt_base} + (CNT_W+1)'(1);
        last       = term && (burst_base != '0) && (tick_num == {1'b0, burst_base});
    end

    sample_tick_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     (div_en),
        .period (period_sel),
        .phase  (phase_w),
        .term   (term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sel_err_q    <= 1'b0;
            tick_count_q <= '0;
            burst_q      <= '0;
        end else begin
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        busy_q       <= 1'b1;
                        burst_q      <= burst_len;
                        sel_err_q    <= (rate_sel > 4'(RATE_MAX));
                        tick_q       <= term;
                        tick_count_q <= term ? CNT_W'(1) : '0;
                        state_q      <= last ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (term) begin
                        tick_q       <= 1'b1;
                        tick_count_q <= (&tick_count_q) ? tick_count_q : tick_count_q + CNT_W'(1);
                        if (last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tick       = tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sel_err    = sel_err_q;
    assign tick_count = tick_count_q;

endmodule
